relu_grad: RTL and testbench
============================

RELU_GRAD -- requirements
Module: relu_grad

Interface
REQ-001 SHALL have parameter input_number, default 100, giving the number of elements per frame.
REQ-002 SHALL have parameter width, default 10, giving the signed element width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fwd_valid  input  1  forward-activation sample valid.
REQ-006 SHALL have port fwd_ready  output  1  block accepts a forward sample.
REQ-007 SHALL have port fwd_data  input  width, signed  forward pre-activation value.
REQ-008 SHALL have port grad_valid  input  1  upstream gradient valid.
REQ-009 SHALL have port grad_ready  output  1  block accepts a gradient.
REQ-010 SHALL have port grad_data  input  width, signed  upstream gradient.
REQ-011 SHALL have port out_valid  output  1  gated gradient valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the gated gradient.
REQ-013 SHALL have port out_data  output  width, signed  gated gradient.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 SHALL implement a two-state FSM: CAPTURE and GRAD.
REQ-016 SHALL define a transfer on any channel as valid and ready both high at a rising edge.
REQ-017 In CAPTURE, fwd_ready SHALL be 1 and grad_ready SHALL be 0.
REQ-018 In CAPTURE, each forward transfer SHALL store mask[idx] = (fwd_data > 0) as a signed strict comparison, then increment idx.
REQ-019 On the forward transfer at idx = input_number-1, the FSM SHALL go to GRAD and reset idx to 0.
REQ-020 In GRAD, fwd_ready SHALL be 0, and fwd_valid SHALL be ignored.
REQ-021 In GRAD, grad_ready SHALL equal (!out_valid || out_ready).
REQ-022 In GRAD, each gradient transfer SHALL load out_data with grad_data if mask[idx] = 1, else 0, SHALL set out_valid, and SHALL increment idx.
REQ-023 Gradient-to-output latency SHALL be exactly 1 cycle.
REQ-024 An output transfer with no same-cycle gradient transfer SHALL clear out_valid.
REQ-025 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 When the last output element (the one from gradient index input_number-1) transfers, the FSM SHALL return to CAPTURE, clear idx, and assert done for the following cycle only.
REQ-027 fwd_ready SHALL be 1 in the same cycle done is 1, so back-to-back frames have no bubble.
REQ-028 idx SHALL be $clog2(input_number) bits wide and SHALL never exceed input_number-1.
REQ-029 A forward value of 0 or the most negative value (-2^(width-1)) SHALL give mask 0.
REQ-030 No arithmetic SHALL be performed on gradients; out_data is a bit-exact copy of grad_data or zero.

Reset
REQ-031 On rst_n low, at any time including mid-frame, the block SHALL set the state to CAPTURE, idx to 0, every mask bit to 0, out_valid to 0, out_data to 0, and done to 0.
REQ-032 After reset release, fwd_ready SHALL be 1 and grad_ready SHALL be 0.

Structure
REQ-033 The FSM state encoding (CAPTURE, GRAD) SHALL reside in the shared package vae_pkg, alongside the default width and input_number constants.
REQ-034 The block SHALL be a single module with no sub-module; the mask SHALL be an input_number-bit register vector.

Verification
REQ-035 With input_number=4 and width=10: fwd {5,-3,0,511}, then grad {7,8,9,-10} -> out {7,0,0,-10}; done pulses once, one cycle after the last output transfer.
REQ-036 Hold out_ready=0 for 3 cycles while element 1 is pending -> out_data stays 0, grad_ready stays 0, and no element is lost or duplicated.
REQ-037 Drive fwd_valid=1 with fwd_data=100 throughout GRAD -> fwd_ready stays 0 and the mask is unchanged.
REQ-038 Assert rst_n=0 after 2 gradient transfers -> out_valid=0 and the state is CAPTURE; a fresh frame fwd {1,1,1,1} with grad {2,3,4,5} -> out {2,3,4,5}.
REQ-039 Send fwd {-512,-1,1,0} with all valids and out_ready held high for two consecutive frames -> out {0,0,g2,0} for each frame, and the second frame's first forward transfer lands in the done cycle.

Source files
------------

// File: rtl/vae_pkg.sv
// Shared VAE datapath constants: default element width/frame size and the ReLU-gradient FSM encoding.
package vae_pkg;

    localparam int DEF_WIDTH        = 10;
    localparam int DEF_INPUT_NUMBER = 100;

    localparam logic [0:0] ST_CAPTURE = 1'b0;
    localparam logic [0:0] ST_GRAD    = 1'b1;

endpackage

// File: rtl/relu_grad.sv
// ReLU backward gate: captures a frame of forward signs into a mask, then gates a frame of gradients; 1-cycle grad->out.
// Backpressure: out_ready stalls grad_ready through a single output register; done pulses the cycle after the last output.
module relu_grad
    import vae_pkg::*;
#(
    parameter int input_number = DEF_INPUT_NUMBER,
    parameter int width        = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fwd_valid,
    output logic                    fwd_ready,
    input  logic signed [width-1:0] fwd_data,
    input  logic                    grad_valid,
    output logic                    grad_ready,
    input  logic signed [width-1:0] grad_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [width-1:0] out_data,
    output logic                    done
);

    localparam int IW = (input_number > 1) ? $clog2(input_number) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(input_number - 1);

    logic [0:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [input_number-1:0] mask_q, mask_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [width-1:0] out_data_q, out_data_d;
    logic                    done_q, done_d;
    // Set once the final gradient of the frame sits in the output register.
    logic                    last_q, last_d;

    logic fwd_xfer, grad_xfer, out_xfer;

    assign fwd_ready  = (state_q == ST_CAPTURE);
    assign grad_ready = (state_q == ST_GRAD) && !last_q && (!out_valid_q || out_ready);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = done_q;

    assign fwd_xfer  = fwd_valid && fwd_ready;
    assign grad_xfer = grad_valid && grad_ready;
    assign out_xfer  = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        last_d      = last_q;
        case (state_q)
            ST_CAPTURE: begin
                if (fwd_xfer) begin
                    mask_d[idx_q] = (fwd_data > 0);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_GRAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_CAPTURE;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                if (grad_xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mask_q[idx_q] ? grad_data : '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CAPTURE;
            idx_q       <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_relu_grad.sv
// Scoreboard bench for relu_grad with a 4-element frame; expected outputs come from a sign mask kept by the bench.
module tb_relu_grad;

    localparam int N = 4;
    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                fwd_valid = 1'b0;
    logic                fwd_ready;
    logic signed [W-1:0] fwd_data = '0;
    logic                grad_valid = 1'b0;
    logic                grad_ready;
    logic signed [W-1:0] grad_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] out_data;
    logic                done;

    relu_grad #(.input_number(N), .width(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mdl_mask[N];
    int   fi = 0;
    int   gi = 0;
    bit   done_exp = 1'b0;
    int   done_cnt = 0;
    bit   fwd_hold = 1'b0;
    bit   dn;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Output side of the scoreboard plus the done-pulse timing check.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp = 1'b0;
            end else begin
                if (done_exp || done) chk("done_pulse", done, done_exp);
                if (done) done_cnt++;
                done_exp = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        if (e.last) done_exp = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send_fwd(input int v, output bit dn_seen);
        bit ok = 1'b0;
        dn_seen   = 1'b0;
        fwd_valid = 1'b1;
        fwd_data  = W'(v);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (fwd_ready) begin
                mdl_mask[fi] = (v > 0);
                fi = (fi + 1) % N;
                dn_seen = done;
                ok = 1'b1;
            end
        end
        if (!ok) chk("fwd_timeout", 0, 1);
        @(posedge clk);
        #1;
        fwd_valid = 1'b0;
    endtask

    task automatic send_grad(input int g);
        exp_t e;
        bit ok = 1'b0;
        grad_valid = 1'b1;
        grad_data  = W'(g);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (fwd_hold) chk("fwd_rdy_in_grad", fwd_ready, 0);
            if (grad_ready) begin
                e.data = mdl_mask[gi] ? g : 0;
                e.last = (gi == N - 1);
                sb.push_back(e);
                gi = (gi + 1) % N;
                ok = 1'b1;
            end
        end
        if (!ok) chk("grad_timeout", 0, 1);
        @(posedge clk);
        #1;
        grad_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        fi = 0;
        gi = 0;
        for (int i = 0; i < N; i++) mdl_mask[i] = 1'b0;
    endtask

    initial begin
        int fa[N] = '{5, -3, 0, 511};
        int fb[N] = '{-1, 2, -3, 4};
        int fc[N] = '{-512, -1, 1, 0};
        int ga[N] = '{11, 22, 33, 44};
        int gb[N] = '{-5, -6, -7, -8};

        apply_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fwd_ready", fwd_ready, 1);
        chk("rst_grad_ready", grad_ready, 0);
        @(posedge clk);
        #1;

        // Frame 1, with element 1 held back by the consumer for three cycles.
        for (int i = 0; i < N; i++) send_fwd(fa[i], dn);
        send_grad(7);
        send_grad(8);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", int'(out_data), 0);
            chk("stall_grad_ready", grad_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_grad(9);
        send_grad(-10);

        // Frame 2: forward traffic held high through the gradient phase.
        for (int i = 0; i < N; i++) send_fwd(fb[i], dn);
        fwd_valid = 1'b1;
        fwd_data  = 10'sd100;
        fwd_hold  = 1'b1;
        for (int i = 0; i < N; i++) send_grad(10 * (i + 1));
        fwd_hold  = 1'b0;
        fwd_valid = 1'b0;

        // Frame 3 aborted by reset after two gradients, then a fresh frame.
        for (int i = 0; i < N; i++) send_fwd(i + 1, dn);
        send_grad(6);
        send_grad(7);
        apply_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_fwd_ready", fwd_ready, 1);
        chk("mid_rst_grad_ready", grad_ready, 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) send_fwd(1, dn);
        for (int i = 0; i < N; i++) send_grad(i + 2);

        // Two back-to-back frames with signed boundary forward values.
        for (int i = 0; i < N; i++) send_fwd(fc[i], dn);
        for (int i = 0; i < N; i++) send_grad(ga[i]);
        for (int i = 0; i < N; i++) begin
            send_fwd(fc[i], dn);
            if (i == 0) chk("b2b_fwd_in_done_cycle", dn, 1);
        end
        for (int i = 0; i < N; i++) send_grad(gb[i]);

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
